if_prefetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the RV32 pipeline; successor to the single-register fetch in stage 1.
- Issues word-aligned reads to instruction memory and buffers up to DEPTH fetched {pc, instr} pairs in a circular queue.
- Presents them to decode over a valid/ready handshake.
- A taken branch/jump flushes the queue and any in-flight read, then redirects fetch.

---
 rtl/if_prefetch_queue.sv | 112 +++++++++++
 tb/tb_if_prefetch_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: RV32 instruction prefetch queue for the fetch stage.
// Issues word reads, buffers {pc, instr} pairs, hands them to decode.
// Ports: clk_i/reset_i (async, active-low); iaddr_o/ird_o/irdata_i
// instruction memory (data one cycle after ird_o); branch_taken_i/
// jump_addr_i redirect; out_valid_o/out_ready_i decode handshake;
// pc_o/next_pc_o/instr_o head entry; count_o occupancy.
module if_prefetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic [31:0]                iaddr_o,
  output logic                       ird_o,
  input  logic [31:0]                irdata_i,
  input  logic                       branch_taken_i,
  input  logic [31:0]                jump_addr_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                pc_o,
  output logic [31:0]                next_pc_o,
  output logic [31:0]                instr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LP_LAST = PW'(DEPTH - 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic          r_inflight;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [31:0]   r_pc_q    [DEPTH];
  logic [31:0]   r_instr_q [DEPTH];

  logic [CW:0]   w_occ;
  logic          w_issue;
  logic          w_push;
  logic          w_valid;
  logic          w_pop;
  logic          w_unused_jaddr;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    if (p == LP_LAST) return '0;
    return p + PW'(1);
  endfunction

  // An outstanding read reserves a slot so a response always fits.
  assign w_occ = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};

  // Gated by reset so no strobe escapes while held in reset.
  assign w_issue = reset_i && !branch_taken_i && (w_occ < LP_DEPTH);
  assign w_push  = r_inflight && !branch_taken_i;
  assign w_valid = (r_count != '0) && !branch_taken_i;
  assign w_pop   = w_valid && out_ready_i;

  assign w_unused_jaddr = ^jump_addr_i[1:0];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (branch_taken_i) begin
      r_fetch_pc <= {jump_addr_i[31:2], 2'b00};
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_req_pc   <= r_fetch_pc;
        r_inflight <= 1'b1;
      end else begin
        r_inflight <= 1'b0;
      end
      if (w_push) r_tail <= f_inc(r_tail);
      if (w_pop)  r_head <= f_inc(r_head);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy and pointers qualify it.
  always_ff @(posedge clk_i) begin
    if (reset_i && w_push) begin
      r_pc_q[r_tail]    <= r_req_pc;
      r_instr_q[r_tail] <= irdata_i;
    end
  end

  assign iaddr_o     = r_fetch_pc;
  assign ird_o       = w_issue;
  assign out_valid_o = w_valid;
  assign pc_o        = w_valid ? r_pc_q[r_head] : 32'h0;
  assign instr_o     = w_valid ? r_instr_q[r_head] : NOP_INSTR;
  assign next_pc_o   = pc_o + 32'd4;
  assign count_o     = r_count;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed table plus randomized model check
// for if_prefetch_queue (DEPTH 4 at pc 0, DEPTH 3 at pc FFFF_FFF8).
module tb_if_prefetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XB  = 32'h5A5A_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic        rst_a, ird_a, br_a, rdy_a, vld_a;
  logic [31:0] iaddr_a, rdata_a, ja_a, pc_a, npc_a, ins_a;
  logic [2:0]  cnt_a;

  logic        rst_b, ird_b, br_b, rdy_b, vld_b;
  logic [31:0] iaddr_b, rdata_b, ja_b, pc_b, npc_b, ins_b;
  logic [1:0]  cnt_b;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u_a (
    .clk_i(clk), .reset_i(rst_a), .iaddr_o(iaddr_a), .ird_o(ird_a),
    .irdata_i(rdata_a), .branch_taken_i(br_a), .jump_addr_i(ja_a),
    .out_valid_o(vld_a), .out_ready_i(rdy_a), .pc_o(pc_a),
    .next_pc_o(npc_a), .instr_o(ins_a), .count_o(cnt_a)
  );

  if_prefetch_queue #(.DEPTH(3), .RESET_PC(32'hFFFF_FFF8)) u_b (
    .clk_i(clk), .reset_i(rst_b), .iaddr_o(iaddr_b), .ird_o(ird_b),
    .irdata_i(rdata_b), .branch_taken_i(br_b), .jump_addr_i(ja_b),
    .out_valid_o(vld_b), .out_ready_i(rdy_b), .pc_o(pc_b),
    .next_pc_o(npc_b), .instr_o(ins_b), .count_o(cnt_b)
  );

  // Instruction memories: data one cycle after the strobe.
  always @(posedge clk)
    rdata_a <= ird_a ? iaddr_a : 32'hDEAD_BEEF;
  always @(posedge clk)
    rdata_b <= ird_b ? (iaddr_b ^ XB) : 32'hDEAD_BEEF;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_a(input string tag, input logic e_ird,
                         input logic [31:0] e_iaddr, input logic e_vld,
                         input logic [31:0] e_pc, input logic [31:0] e_ins,
                         input logic [2:0] e_cnt);
    check({tag, "_ird"},   32'(ird_a),   32'(e_ird));
    check({tag, "_iaddr"}, iaddr_a,      e_iaddr);
    check({tag, "_valid"}, 32'(vld_a),   32'(e_vld));
    check({tag, "_pc"},    pc_a,         e_pc);
    check({tag, "_npc"},   npc_a,        e_pc + 32'd4);
    check({tag, "_instr"}, ins_a,        e_ins);
    check({tag, "_count"}, 32'(cnt_a),   32'(e_cnt));
  endtask

  typedef struct {
    logic        br;
    logic [31:0] ja;
    logic        rdy;
    logic        ird;
    logic [31:0] iaddr;
    logic        vld;
    logic [31:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  function automatic vec_t mk(input logic br, input logic [31:0] ja,
                              input logic rdy, input logic ird,
                              input logic [31:0] iaddr, input logic vld,
                              input logic [31:0] pc, input logic [2:0] cnt);
    vec_t v;
    v.br = br; v.ja = ja; v.rdy = rdy; v.ird = ird;
    v.iaddr = iaddr; v.vld = vld; v.pc = pc; v.cnt = cnt;
    return v;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  vec_t tv[33];
  ent_t mq[$];

  initial begin
    logic [31:0] m_fetch, m_inf_pc, e_pc, e_ins;
    int          m_inf;
    logic        e_vld, e_ird;
    int          found;

    // backpressure fill, single pop, drain, flush with read in flight
    tv[0]  = mk(0, 0, 0, 1, 32'h000, 0, 32'h000, 0);
    tv[1]  = mk(0, 0, 0, 1, 32'h004, 0, 32'h000, 0);
    tv[2]  = mk(0, 0, 0, 1, 32'h008, 1, 32'h000, 1);
    tv[3]  = mk(0, 0, 0, 1, 32'h00C, 1, 32'h000, 2);
    tv[4]  = mk(0, 0, 0, 0, 32'h010, 1, 32'h000, 3);
    tv[5]  = mk(0, 0, 0, 0, 32'h010, 1, 32'h000, 4);
    tv[6]  = mk(0, 0, 1, 0, 32'h010, 1, 32'h000, 4);
    tv[7]  = mk(0, 0, 0, 1, 32'h010, 1, 32'h004, 3);
    tv[8]  = mk(0, 0, 0, 0, 32'h014, 1, 32'h004, 3);
    tv[9]  = mk(0, 0, 0, 0, 32'h014, 1, 32'h004, 4);
    tv[10] = mk(0, 0, 1, 0, 32'h014, 1, 32'h004, 4);
    tv[11] = mk(0, 0, 1, 1, 32'h014, 1, 32'h008, 3);
    tv[12] = mk(0, 0, 1, 1, 32'h018, 1, 32'h00C, 2);
    tv[13] = mk(0, 0, 1, 1, 32'h01C, 1, 32'h010, 2);
    tv[14] = mk(0, 0, 0, 1, 32'h020, 1, 32'h014, 2);
    tv[15] = mk(1, 32'h103, 0, 0, 32'h024, 0, 32'h000, 3);
    tv[16] = mk(0, 0, 1, 1, 32'h100, 0, 32'h000, 0);
    tv[17] = mk(0, 0, 1, 1, 32'h104, 0, 32'h000, 0);
    tv[18] = mk(0, 0, 1, 1, 32'h108, 1, 32'h100, 1);
    tv[19] = mk(0, 0, 1, 1, 32'h10C, 1, 32'h104, 1);
    // stall to full, branch while full
    tv[20] = mk(0, 0, 0, 1, 32'h110, 1, 32'h108, 1);
    tv[21] = mk(0, 0, 0, 1, 32'h114, 1, 32'h108, 2);
    tv[22] = mk(0, 0, 0, 0, 32'h118, 1, 32'h108, 3);
    tv[23] = mk(0, 0, 0, 0, 32'h118, 1, 32'h108, 4);
    tv[24] = mk(1, 32'h200, 0, 0, 32'h118, 0, 32'h000, 4);
    tv[25] = mk(0, 0, 1, 1, 32'h200, 0, 32'h000, 0);
    tv[26] = mk(0, 0, 1, 1, 32'h204, 0, 32'h000, 0);
    tv[27] = mk(0, 0, 1, 1, 32'h208, 1, 32'h200, 1);
    // back-to-back branches, last one wins
    tv[28] = mk(1, 32'h300, 1, 0, 32'h20C, 0, 32'h000, 1);
    tv[29] = mk(1, 32'h402, 1, 0, 32'h300, 0, 32'h000, 0);
    tv[30] = mk(0, 0, 1, 1, 32'h400, 0, 32'h000, 0);
    tv[31] = mk(0, 0, 1, 1, 32'h404, 0, 32'h000, 0);
    tv[32] = mk(0, 0, 1, 1, 32'h408, 1, 32'h400, 1);

    rst_a = 1'b0; br_a = 1'b0; ja_a = '0; rdy_a = 1'b0;
    rst_b = 1'b0; br_b = 1'b0; ja_b = '0; rdy_b = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_a("A_reset", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 3'd0);

    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 0; i < 33; i++) begin
      if (i > 0) @(negedge clk);
      br_a = tv[i].br; ja_a = tv[i].ja; rdy_a = tv[i].rdy;
      #1;
      check_a($sformatf("A_v%0d", i), tv[i].ird, tv[i].iaddr,
              tv[i].vld, tv[i].pc,
              tv[i].vld ? tv[i].pc : NOP, tv[i].cnt);
    end

    // async reset between edges with two entries queued
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge clk);
      br_a = 1'b0; rdy_a = 1'b0;
      #1;
      if (cnt_a == 3'd2) found = 1;
    end
    check("A_mid_count_reached", 32'(found), 32'd1);
    #2 rst_a = 1'b0;
    #1;
    check_a("A_midrst", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 3'd0);
    @(negedge clk);
    rst_a = 1'b1; rdy_a = 1'b1;
    #1;
    check_a("A_rel0", 1'b1, 32'h0, 1'b0, 32'h0, NOP, 3'd0);
    @(negedge clk);
    #1;
    check_a("A_rel1", 1'b1, 32'h4, 1'b0, 32'h0, NOP, 3'd0);
    @(negedge clk);
    #1;
    check_a("A_rel2", 1'b1, 32'h8, 1'b1, 32'h0, 32'h0, 3'd1);

    // randomized run on the DEPTH 3 instance against a queue model
    m_fetch = 32'hFFFF_FFF8; m_inf = 0; m_inf_pc = '0;
    mq.delete();
    @(negedge clk);
    rst_b = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (k > 0) @(negedge clk);
      br_b = (k >= 40) && ($urandom_range(0, 15) == 0);
      ja_b = $urandom;
      if (k < 120)
        rdy_b = k[0];
      else if (k >= 300 && k < 330)
        rdy_b = 1'b0;
      else
        rdy_b = ($urandom_range(0, 3) != 0);
      #1;
      e_vld = (mq.size() != 0) && !br_b;
      e_pc  = e_vld ? mq[0].pc : 32'h0;
      e_ins = e_vld ? mq[0].instr : NOP;
      e_ird = !br_b && (mq.size() + m_inf < 3);
      check("B_ird",   32'(ird_b), 32'(e_ird));
      check("B_iaddr", iaddr_b,    m_fetch);
      check("B_valid", 32'(vld_b), 32'(e_vld));
      check("B_pc",    pc_b,       e_pc);
      check("B_npc",   npc_b,      e_pc + 32'd4);
      check("B_instr", ins_b,      e_ins);
      check("B_count", 32'(cnt_b), 32'(mq.size()));
      check("B_count_le_depth", 32'(cnt_b <= 2'd3), 32'd1);
      @(posedge clk);
      if (br_b) begin
        mq.delete();
        m_inf = 0;
        m_fetch = {ja_b[31:2], 2'b00};
      end else begin
        if (e_vld && rdy_b) void'(mq.pop_front());
        if (m_inf != 0) mq.push_back({m_inf_pc, m_inf_pc ^ XB});
        if (e_ird) begin
          m_inf = 1;
          m_inf_pc = m_fetch;
          m_fetch = m_fetch + 32'd4;
        end else begin
          m_inf = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
